// File: rtl/hpdmc_pkg.sv
// Shared constants for the HPDMC data-phase timing tracker: CAS latency
// encoding, default burst length / counter width and bank one-hot width.
package hpdmc_pkg;

  localparam logic CL2 = 1'b0;
  localparam logic CL3 = 1'b1;

  localparam int DEFAULT_BURST_CYCLES = 2;
  localparam int DEFAULT_CNT_WIDTH    = 4;

  localparam int BANK_W   = 4;
  localparam int CAP_SR_W = 8;

endpackage

// File: rtl/hpdmc_dt_counter.sv
// Loadable down-counter with zero flag. With max_on_load set, a load never
// shortens the time still pending on the counter.
module hpdmc_dt_counter #(
  parameter int cnt_width   = 4,
  parameter bit max_on_load = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [cnt_width-1:0] load_val,
  output logic                 zero
);

  logic [cnt_width-1:0] cnt_q;
  logic [cnt_width-1:0] cnt_d;
  logic [cnt_width-1:0] cnt_dec;

  // Compare against the value the counter would hold next cycle, so the
  // longer of "remaining time" and "new load" wins.
  always_comb begin
    cnt_dec = (cnt_q != '0) ? cnt_q - {{(cnt_width-1){1'b0}}, 1'b1} : cnt_q;
    cnt_d   = cnt_dec;
    if (load) begin
      if (max_on_load && (cnt_dec > load_val)) begin
        cnt_d = cnt_dec;
      end else begin
        cnt_d = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hpdmc_datactl_timing.sv
// Data-phase timing tracker downstream of the SDRAM command FSM.
// Optional busy counter enabled by defining HPDMC_DATACTL_BUSY_COUNT_EN.
module hpdmc_datactl_timing
  import hpdmc_pkg::*;
#(
  parameter int burst_cycles = DEFAULT_BURST_CYCLES,
  parameter int cnt_width    = DEFAULT_CNT_WIDTH
) (
  input  logic              sys_clk,
  input  logic              sdram_rst,
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
  input  logic              busy_clr,
  output logic [31:0]       busy_count,
`endif
  input  logic              read,
  input  logic              write,
  input  logic [BANK_W-1:0] concerned_bank,
  input  logic              tim_cas,
  input  logic [1:0]        tim_wr,
  output logic              read_safe,
  output logic              write_safe,
  output logic [BANK_W-1:0] precharge_safe,
  output logic              direction,
  output logic              direction_r,
  output logic              read_capture
);

  localparam int CNT_MAX = (1 << cnt_width) - 1;

  function automatic logic [cnt_width-1:0] sat_load(input int v);
    return (v > CNT_MAX) ? CNT_MAX[cnt_width-1:0] : v[cnt_width-1:0];
  endfunction

  // read/write are single-cycle command strobes from the FSM: a high level
  // means the command is issued that cycle, there is no back-pressure.
  logic cmd_wr;
  logic cmd_rd;
  logic cmd_any;
  int   cl;

  assign cmd_wr  = write;
  assign cmd_rd  = read & ~write;
  assign cmd_any = read | write;

  always_comb begin
    cl = (tim_cas == CL3) ? 3 : 2;
  end

  logic [cnt_width-1:0] rs_load;
  logic [cnt_width-1:0] ws_load;
  logic [cnt_width-1:0] pre_load;
  logic [cnt_width-1:0] dir_load;

  always_comb begin
    rs_load  = cmd_wr ? sat_load(burst_cycles + 1) : sat_load(burst_cycles - 1);
    ws_load  = cmd_wr ? sat_load(burst_cycles - 1) : sat_load(cl + burst_cycles);
    pre_load = cmd_wr ? sat_load(burst_cycles + 1 + int'(tim_wr))
                      : sat_load(burst_cycles);
    dir_load = sat_load(burst_cycles);
  end

  hpdmc_dt_counter #(.cnt_width(cnt_width), .max_on_load(1'b0)) u_read_safe (
    .clk(sys_clk), .rst(sdram_rst), .load(cmd_any), .load_val(rs_load),
    .zero(read_safe)
  );

  hpdmc_dt_counter #(.cnt_width(cnt_width), .max_on_load(1'b0)) u_write_safe (
    .clk(sys_clk), .rst(sdram_rst), .load(cmd_any), .load_val(ws_load),
    .zero(write_safe)
  );

  for (genvar b = 0; b < BANK_W; b++) begin : g_pre
    hpdmc_dt_counter #(.cnt_width(cnt_width), .max_on_load(1'b1)) u_pre (
      .clk(sys_clk), .rst(sdram_rst), .load(cmd_any & concerned_bank[b]),
      .load_val(pre_load), .zero(precharge_safe[b])
    );
  end

  // Reloading on every write keeps the bus driven across back-to-back writes.
  logic dir_idle;

  hpdmc_dt_counter #(.cnt_width(cnt_width), .max_on_load(1'b0)) u_dir (
    .clk(sys_clk), .rst(sdram_rst), .load(cmd_wr), .load_val(dir_load),
    .zero(dir_idle)
  );

  assign direction = ~dir_idle;

  logic direction_r_q;
  logic direction_r_d;

  assign direction_r_d = direction;
  assign direction_r   = direction_r_q;

  // Bit i reaches bit 0 i+1 clocks after the command, so the window is
  // placed at bits CL-1 .. CL+burst-2 using the CAS latency of that command.
  logic [CAP_SR_W-1:0] cap_sr_q;
  logic [CAP_SR_W-1:0] cap_sr_d;
  logic [CAP_SR_W-1:0] cap_mask;

  always_comb begin
    cap_mask = '0;
    for (int i = 0; i < CAP_SR_W; i++) begin
      if ((i >= cl - 1) && (i < cl - 1 + burst_cycles)) begin
        cap_mask[i] = 1'b1;
      end
    end
    cap_sr_d = (cap_sr_q >> 1) | (cmd_rd ? cap_mask : '0);
  end

  assign read_capture = cap_sr_q[0];

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      direction_r_q <= 1'b0;
      cap_sr_q      <= '0;
    end else begin
      direction_r_q <= direction_r_d;
      cap_sr_q      <= cap_sr_d;
    end
  end

`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (busy_clr) begin
      busy_d = '0;
    end else if (direction || read_capture) begin
      busy_d = busy_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_count = busy_q;
`endif

`ifndef SYNTHESIS
  rw_exclusive: assert property (@(posedge sys_clk) disable iff (sdram_rst)
    !(read && write))
    else $error("read and write issued in the same cycle");
`endif

endmodule

// File: tb/tb_hpdmc_datactl_timing.sv
// Randomized scoreboard bench for hpdmc_datactl_timing; the reference model
// tracks, per output, the first cycle at which it becomes safe again.
module tb_hpdmc_datactl_timing;

  localparam int B    = 2;
  localparam int CMAX = 15;
  localparam int NCYC = 8192;
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
  localparam int EW = 41;
`else
  localparam int EW = 9;
`endif

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sdram_rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  concerned_bank = 4'h0;
  logic        tim_cas = 1'b0;
  logic [1:0]  tim_wr = 2'd0;
  logic        busy_clr = 1'b0;
  logic        read_safe, write_safe, direction, direction_r, read_capture;
  logic [3:0]  precharge_safe;
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
  logic [31:0] busy_count;
`endif

  hpdmc_datactl_timing dut (
    .sys_clk(sys_clk),
    .sdram_rst(sdram_rst),
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
    .busy_clr(busy_clr),
    .busy_count(busy_count),
`endif
    .read(read),
    .write(write),
    .concerned_bank(concerned_bank),
    .tim_cas(tim_cas),
    .tim_wr(tim_wr),
    .read_safe(read_safe),
    .write_safe(write_safe),
    .precharge_safe(precharge_safe),
    .direction(direction),
    .direction_r(direction_r),
    .read_capture(read_capture)
  );

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          model_valid = 1'b0;
  int          read_ok, write_ok, dir_end;
  int          pre_ok[4];
  bit          cap_mark[NCYC];
  bit          dir_r_model;
  logic [31:0] busy_model;

  function automatic int ld(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit dir_at(input int c);
    return c <= dir_end;
  endfunction

  function automatic logic [EW-1:0] expected_now();
    logic [8:0] base;
    logic [3:0] pre;
    for (int b = 0; b < 4; b++) pre[b] = (cyc >= pre_ok[b]);
    base = {cyc >= read_ok, cyc >= write_ok, pre, dir_at(cyc), dir_r_model,
            cap_mark[cyc]};
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
    return {base, busy_model};
`else
    return base;
`endif
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [3:0] bk,
                              input logic cas, input logic [1:0] wr,
                              input logic rs, input logic clr);
    int t, cl;
    t  = cyc;
    cl = cas ? 3 : 2;
    if (rs) begin
      read_ok = t + 1;
      write_ok = t + 1;
      for (int b = 0; b < 4; b++) pre_ok[b] = t + 1;
      dir_end = t;
      for (int k = 1; k < 16; k++) cap_mark[t + k] = 1'b0;
      dir_r_model = 1'b0;
      busy_model = '0;
      model_valid = 1'b1;
    end else begin
      if (clr) busy_model = '0;
      else if (dir_at(t) || cap_mark[t]) busy_model = busy_model + 32'd1;
      dir_r_model = dir_at(t);
      if (w) begin
        read_ok  = t + ld(B + 1) + 1;
        write_ok = t + ld(B - 1) + 1;
        for (int b = 0; b < 4; b++)
          if (bk[b] && (t + ld(B + 1 + int'(wr)) + 1 > pre_ok[b]))
            pre_ok[b] = t + ld(B + 1 + int'(wr)) + 1;
        dir_end = t + B;
      end else if (r) begin
        read_ok  = t + ld(B - 1) + 1;
        write_ok = t + ld(cl + B) + 1;
        for (int b = 0; b < 4; b++)
          if (bk[b] && (t + ld(B) + 1 > pre_ok[b])) pre_ok[b] = t + ld(B) + 1;
        for (int k = 0; k < B; k++) cap_mark[t + cl + k] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_compared = 0;
  int n_mismatched = 0;

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input logic [3:0] bk,
                      input logic cas, input logic [1:0] wr,
                      input logic rs, input logic clr);
    @(posedge sys_clk);
    #1;
    if (model_valid) exp_q.push_back(expected_now());
    read = r; write = w; concerned_bank = bk; tim_cas = cas; tim_wr = wr;
    sdram_rst = rs; busy_clr = clr;
    model_update(r, w, bk, cas, wr, rs, clr);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0, 2'd0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef HPDMC_DATACTL_BUSY_COUNT_EN
        a = {read_safe, write_safe, precharge_safe, direction, direction_r,
             read_capture, busy_count};
`else
        a = {read_safe, write_safe, precharge_safe, direction, direction_r,
             read_capture};
`endif
        n_compared++;
        if (a !== e) begin
          n_mismatched++;
          $display("FAIL outputs t=%0t {rs,ws,pre,dir,dir_r,cap[,busy]} got=%h exp=%h",
                   $time, a, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [3:0] bk;
    step(0, 0, 4'h0, 0, 2'd0, 1, 0);
    step(0, 0, 4'h0, 0, 2'd0, 1, 0);
    idle(6);
    // read, bank 1, CL2
    step(1, 0, 4'b0010, 0, 2'd0, 0, 0);
    idle(8);
    // write, bank 0, tim_wr=2
    step(0, 1, 4'b0001, 0, 2'd2, 0, 0);
    idle(8);
    // write bank 0 tim_wr=3, read bank 0 four clocks later
    step(0, 1, 4'b0001, 0, 2'd3, 0, 0);
    idle(3);
    step(1, 0, 4'b0001, 0, 2'd0, 0, 0);
    idle(8);
    // back-to-back CL3 reads, tim_cas flips mid-flight
    step(1, 0, 4'b0100, 1, 2'd0, 0, 0);
    step(0, 0, 4'b0000, 0, 2'd0, 0, 0);
    step(1, 0, 4'b1000, 1, 2'd0, 0, 0);
    step(0, 0, 4'b0000, 0, 2'd0, 0, 0);
    idle(8);
    // back-to-back writes
    step(0, 1, 4'b0010, 0, 2'd1, 0, 0);
    step(0, 0, 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 4'b0010, 0, 2'd1, 0, 0);
    idle(6);
    // write then reset one clock later, with a command held during reset
    step(0, 1, 4'b0001, 0, 2'd3, 0, 0);
    step(1, 0, 4'b1111, 1, 2'd0, 1, 0);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 9);
      bk = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'(1 << $urandom_range(0, 3));
      step(kind <= 2, (kind >= 3) && (kind <= 5), bk, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0);
    end
    idle(12);
    repeat (3) @(negedge sys_clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hpdmc_datactl_timing.md
Name: hpdmc_datactl_timing

Overview:
- Data-phase timing tracker that sits directly downstream of the SDRAM command FSM.
- Consumes the FSM's per-cycle read/write command strobes and the one-hot target bank.
- Returns read_safe, write_safe and per-bank precharge_safe back to the FSM.
- Generates DQ output-enable and read-capture windows for the PHY/data path, so the FSM never violates bus turnaround, CAS latency or write recovery.

Parameters:
- burst_cycles, 2, clocks the data bus is occupied per command (legal 1..4)
- cnt_width, 4, width of all internal down-counters

Ports:
- sys_clk  in  1  system clock
- sdram_rst  in  1  synchronous active-high reset
- read  in  1  READ command issued this cycle
- write  in  1  WRITE command issued this cycle
- concerned_bank  in  4  one-hot bank of current command
- tim_cas  in  1  0 = CL2, 1 = CL3
- tim_wr  in  2  extra write-recovery clocks (0..3)
- read_safe  out  1  READ may be issued this cycle
- write_safe  out  1  WRITE may be issued this cycle
- precharge_safe  out  4  per-bank PRECHARGE allowed
- direction  out  1  DQ output enable (controller drives bus)
- direction_r  out  1  direction delayed one clock (DQS/DM enable)
- read_capture  out  1  capture read data this cycle

Behaviour:
- Command cycle = T: cycle in which read/write is high. All counters load at the edge ending T.
- Each counter: output "safe" = (count == 0); counts down by 1 per clock while nonzero.
- CL = 2 when tim_cas = 0, CL = 3 when tim_cas = 1.
- read_safe counter:
  - load burst_cycles-1 on read; load burst_cycles+1 on write.
  - Default: read at T → read_safe low T+1, high T+2. Write at T → low T+1..T+3, high T+4.
- write_safe counter:
  - load burst_cycles-1 on write; load CL+burst_cycles on read.
  - Default: read at T → low T+1..T+4 (CL2) / T+1..T+5 (CL3).
- precharge_safe[b], per bank, only for bits set in concerned_bank:
  - read loads burst_cycles; write loads burst_cycles+1+tim_wr.
  - Load value = max(current, new), so a later read never shortens pending write recovery.
- direction:
  - high for burst_cycles clocks starting T+1 after write; back-to-back writes keep it continuously high.
  - implemented as a burst-length shift/counter, not combinational from write.
- direction_r = direction registered.
- read_capture:
  - high for burst_cycles clocks starting T+CL after read.
  - use an 8-bit shift register.
  - tim_cas is sampled at command time; a tim_cas change mid-flight does not move already-scheduled windows.
- Illegal read & write in same cycle: treated as write. A simulation-only assertion flags it.
- Reset values, taking effect the cycle after sdram_rst is sampled high, including mid-burst:
  - all counters 0, so read_safe = 1, write_safe = 1, precharge_safe = 4'b1111;
  - direction = 0, direction_r = 0, read_capture = 0, shift registers cleared.
- Commands present during reset are ignored.
- Counter saturation: loads never exceed 2^cnt_width-1. Max load is 8 with burst_cycles = 4, tim_wr = 3.

Optional Feature:
- Macro HPDMC_DATACTL_BUSY_COUNT_EN.
- Defined:
  - adds input busy_clr (1) and output busy_count (32).
  - busy_count increments each clock where direction or read_capture is high.
  - busy_count wraps at 2^32; busy_clr zeroes it next clock and has priority over increment; reset zeroes it.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package hpdmc_pkg:
  - CL encoding constants (CL2 = 1'b0, CL3 = 1'b1);
  - default burst_cycles and counter width;
  - bank one-hot width.
- Sub-module hpdmc_dt_counter: loadable down-counter with max-on-load option and zero flag.
  - Instantiated for read_safe, write_safe and 4x precharge.

Test Plan:
- Reset then idle → read_safe = 1, write_safe = 1, precharge_safe = 4'hF, direction = 0, read_capture = 0 constant.
- read @T, bank 4'b0010, tim_cas = 0 → read_safe low T+1 only; write_safe low T+1..T+4; precharge_safe[1] low T+1..T+2; read_capture high T+2..T+3.
- write @T, bank 4'b0001, tim_wr = 2 → direction high T+1..T+2; direction_r high T+2..T+3; read_safe low T+1..T+3; precharge_safe[0] low T+1..T+5.
- write @T bank 0, tim_wr = 3, then read @T+4 bank 0 → precharge_safe[0] stays low through T+6 (max rule), high T+7.
- read @T with tim_cas = 1, back-to-back reads @T, T+2 → read_capture continuously high T+3..T+6.
- write @T, sdram_rst high @T+1 → at T+2 all safe outputs high, direction = 0, read_capture = 0. With HPDMC_DATACTL_BUSY_COUNT_EN: busy_count = 0.
